// File: rtl/keypad_scan_entry.sv
// 4x4 active-low keypad scanner with frame debouncing; accepted digits shift into a 32-bit operand.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-fire a held key every REPEAT_FRAMES frames.
module keypad_scan_entry #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_FRAMES  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_in,
   input  logic        entry_clr,
   output logic [3:0]  col_out,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [31:0] value,
   output logic [3:0]  digit_cnt
);

   localparam int TW   = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
   // All per-frame counters share one width, sized for the larger limit.
   localparam int CMAX = (DEBOUNCE_SCANS > REPEAT_FRAMES) ? DEBOUNCE_SCANS : REPEAT_FRAMES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [TW-1:0] TRANS_LAST = TW'(SCAN_DIV);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_SCANS - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam logic [CW-1:0] RPT_LAST   = CW'(REPEAT_FRAMES - 1);
`endif

   typedef enum logic [1:0] {IDLE, DEB, PRESSED} state_t;

   // Returns {hit, multi, row_idx[1:0]} for one active-low row sample.
   function automatic logic [3:0] row_decode(input logic [3:0] rows_n);
      logic [3:0] low;
      low = ~rows_n;
      case (low)
         4'b0000: row_decode = 4'b0000;
         4'b0001: row_decode = 4'b1000;
         4'b0010: row_decode = 4'b1001;
         4'b0100: row_decode = 4'b1010;
         4'b1000: row_decode = 4'b1011;
         default: row_decode = 4'b0100;
      endcase
   endfunction

   logic [TW-1:0] trans;
   logic [1:0]    col;
   logic          acc_hit, acc_multi;
   logic [3:0]    acc_code;
   logic          sample, frame_end;
   logic [3:0]    rd, cur_code, f_code;
   logic          f_multi, f_key, f_none;

   state_t        state, state_nx;
   logic [3:0]    cand, cand_nx;
   logic [CW-1:0] cnt, cnt_nx, rel, rel_nx;
   logic          fire;
`ifdef KEYPAD_AUTOREPEAT_EN
   logic [CW-1:0] rpt, rpt_nx;
`endif

   assign col_out   = ~(4'b0001 << col);
   assign sample    = (trans == TRANS_LAST);
   assign frame_end = sample && (col == 2'd3);
   assign rd        = row_decode(row_in);
   assign cur_code  = {rd[1:0], col};
   assign f_multi   = acc_multi | rd[2] | (acc_hit & rd[3]);
   assign f_key     = !f_multi && (acc_hit || rd[3]);
   assign f_none    = !f_multi && !f_key;
   assign f_code    = rd[3] ? cur_code : acc_code;

   // Scan stage: slot divider, column rotation and per-frame hit accumulation
   always_ff @(posedge clk) begin
      if (rst) begin
         trans     <= '0;
         col       <= 2'd0;
         acc_hit   <= 1'b0;
         acc_multi <= 1'b0;
      end else begin
         if (sample) begin
            trans <= '0;
            col   <= col + 2'd1;
         end else begin
            trans <= trans + TW'(1);
         end
         if (frame_end) begin
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
         end else if (sample) begin
            acc_multi <= f_multi;
            if (rd[3]) acc_hit <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sample && rd[3]) acc_code <= cur_code;
      cand <= cand_nx;
   end

   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      cnt_nx   = cnt;
      rel_nx   = rel;
      fire     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_nx   = rpt;
`endif
      if (frame_end) begin
         unique case (state)
            IDLE: begin
               if (f_key) begin
                  cand_nx = f_code;
                  cnt_nx  = CW'(1);
                  rel_nx  = '0;
                  if (DEB_LAST == '0) begin
                     state_nx = PRESSED;
                     fire     = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rpt_nx   = '0;
`endif
                  end else begin
                     state_nx = DEB;
                  end
               end
            end
            DEB: begin
               if (f_key && f_code == cand) begin
                  if (cnt == DEB_LAST) begin
                     state_nx = PRESSED;
                     fire     = 1'b1;
                     rel_nx   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rpt_nx   = '0;
`endif
                  end else begin
                     cnt_nx = cnt + CW'(1);
                  end
               end else if (f_key) begin
                  cand_nx = f_code;
                  cnt_nx  = CW'(1);
               end else begin
                  state_nx = IDLE;
               end
            end
            PRESSED: begin
               if (f_none) begin
                  if (rel == DEB_LAST) state_nx = IDLE;
                  else                 rel_nx   = rel + CW'(1);
               end else begin
                  rel_nx = '0;
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               if (f_key && f_code == cand) begin
                  if (rpt == RPT_LAST) begin
                     fire   = 1'b1;
                     rpt_nx = '0;
                  end else begin
                     rpt_nx = rpt + CW'(1);
                  end
               end else begin
                  rpt_nx = '0;
               end
`endif
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Event stage: key pulse, code latch and operand shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rel       <= '0;
         key_valid <= 1'b0;
         key_code  <= 4'd0;
         value     <= 32'd0;
         digit_cnt <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt       <= '0;
`endif
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         rel       <= rel_nx;
         key_valid <= fire;
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt       <= rpt_nx;
`endif
         if (fire) key_code <= cand_nx;
         if (entry_clr) begin
            value     <= 32'd0;
            digit_cnt <= 4'd0;
         end else if (key_valid) begin
            value <= {value[27:0], key_code};
            if (digit_cnt != 4'd8) digit_cnt <= digit_cnt + 4'd1;
         end
      end
   end

endmodule
